pc_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the dOrv32 core. It generates sequential fetch addresses and issues them on a req/gnt/rvalid instruction-memory port with several requests in flight. Returned instructions are buffered in a prefetch FIFO and handed to decode as {pc, instr} pairs over a valid/ready handshake. Jump/branch redirects flush all queued and in-flight fetches.

---
 rtl/dorv_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/pc_fetch_queue.sv | 88 ++++++++
 tb/tb_pc_fetch_queue.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dorv_pkg.sv
// Shared dOrv32 constants used by the fetch front end.
package dorv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; head is zero while empty.
module fetch_fifo
    import dorv_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic                            clear,
    input  logic [WIDTH-1:0]                wdata,
    output logic [WIDTH-1:0]                rdata,
    output logic [cnt_width(DEPTH)-1:0]     count,
    output logic                            empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

    // Gating with empty keeps the head at zero after reset without resetting the array.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order
// response capture into a prefetch FIFO, and redirect flush with stale-response drop.
module pc_fetch_queue #(
    parameter int unsigned          XLEN     = dorv_pkg::XLEN,
    parameter int unsigned          ILEN     = dorv_pkg::ILEN,
    parameter logic [XLEN-1:0]      RESET_PC = dorv_pkg::RESET_PC,
    parameter int unsigned          QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  flush_addr_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic             imem_rvalid_i,
    input  logic [ILEN-1:0]  imem_rdata_i,
    output logic             if_valid_o,
    output logic [XLEN-1:0]  if_pc_o,
    output logic [ILEN-1:0]  if_instr_o,
    input  logic             if_ready_i
);

    localparam int unsigned     CW   = dorv_pkg::cnt_width(QDEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(dorv_pkg::PC_STEP);

    logic [XLEN-1:0]      fetch_pc;
    logic [XLEN-1:0]      wr_pc;
    logic [XLEN-1:0]      flush_target;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        drop;
    logic [CW-1:0]        count;
    logic [CW:0]          in_use;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic [XLEN+ILEN-1:0] head;

    // Every in-flight request already owns a FIFO slot, so responses never overflow.
    assign in_use       = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o   = rst && !flush_i && (in_use < (CW+1)'(QDEPTH));
    assign imem_addr_o  = fetch_pc;
    assign issue        = imem_req_o && imem_gnt_i;
    assign push         = imem_rvalid_i && !flush_i && (drop == '0);
    assign pop          = if_ready_i && !empty && !flush_i;
    assign flush_target = flush_addr_i & ~XLEN'(3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            wr_pc       <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (flush_i) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc    <= flush_target;
            wr_pc       <= flush_target;
            outstanding <= outstanding - CW'(imem_rvalid_i);
            drop        <= outstanding - CW'(imem_rvalid_i);
        end else begin
            if (issue) fetch_pc <= fetch_pc + STEP;
            if (push)  wr_pc    <= wr_pc + STEP;
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid_i);
            if (imem_rvalid_i && (drop != '0)) drop <= drop - CW'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush_i),
        .wdata ({wr_pc, imem_rdata_i}),
        .rdata (head),
        .count (count),
        .empty (empty)
    );

    assign if_valid_o = !empty;
    assign if_pc_o    = head[XLEN+ILEN-1:ILEN];
    assign if_instr_o = head[ILEN-1:0];

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed bench for pc_fetch_queue; the memory returns addr ^ MASK one cycle after grant when enabled.
module tb_pc_fetch_queue;

    localparam logic [31:0] MASK = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = '0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        ready = 1'b0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_gnt = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_issued = 0;
    logic [31:0] pend [$];
    bit          resp_en = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_queue #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr), .if_ready_i(ready)
    );

    pc_fetch_queue #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) u_wrap (
        .clk(clk), .rst(rst), .flush_i(w_zero), .flush_addr_i(w_zero32),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
        .imem_rvalid_i(w_zero), .imem_rdata_i(w_zero32),
        .if_valid_o(w_valid), .if_pc_o(w_pc), .if_instr_o(w_instr), .if_ready_i(w_zero)
    );

    // One clock: record grant/response seen before the edge, then present the next response.
    task automatic tick();
        logic        issued;
        logic        took;
        logic [31:0] a;
        #1;
        issued = req && gnt;
        a      = addr;
        took   = rvalid;
        @(posedge clk);
        #1;
        if (took && pend.size() > 0) void'(pend.pop_front());
        if (issued) begin
            pend.push_back(a);
            n_issued++;
        end
        if (resp_en && pend.size() > 0) begin
            rvalid = 1'b1;
            rdata  = pend[0] ^ MASK;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush_i = 1'b0; flush_addr_i = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0; resp_en = 1'b0;
        pend.delete();
        n_issued = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; gnt = 1'b1; ready = 1'b1;
        #3;
        if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
        n_checks++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        n_checks++;
        if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
        n_checks++;
        if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", if_instr); end
        n_checks++;
        do_reset();
        if (req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b expected 1", req); end
        n_checks++;
        if (addr !== 32'h0) begin n_fail++; $display("FAIL release_addr: got %h expected 0", addr); end
        n_checks++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        gnt = 1'b1; resp_en = 1'b1; ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (req !== 1'b1 || addr !== 32'(4 * i)) begin
                n_fail++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, req, addr, 32'(4 * i));
            end
            n_checks++;
            if (i >= 2) begin
                exp_pc = 32'(4 * (i - 2));
                if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== (exp_pc ^ MASK)) begin
                    n_fail++; $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                                       i, if_valid, if_pc, if_instr, exp_pc, exp_pc ^ MASK);
                end
                n_checks++;
            end
            tick();
        end
    endtask

    task automatic test_credit();
        do_reset();
        gnt = 1'b1; resp_en = 1'b1; ready = 1'b0;
        repeat (8) tick();
        if (n_issued != 4) begin n_fail++; $display("FAIL credit_issued: got %0d expected 4", n_issued); end
        n_checks++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL credit_req_low: got %b expected 0", req); end
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL credit_head: got v=%b pc=%h expected v=1 pc=0", if_valid, if_pc);
        end
        n_checks++;
        ready = 1'b1;
        tick();
        if (if_pc !== 32'h4 || req !== 1'b1 || addr !== 32'h10) begin
            n_fail++; $display("FAIL credit_resume: got pc=%h req=%b addr=%h expected pc=4 req=1 addr=10", if_pc, req, addr);
        end
        n_checks++;
        tick();
        if (if_pc !== 32'h8) begin n_fail++; $display("FAIL credit_pop2: got %h expected 8", if_pc); end
        n_checks++;
        tick();
        if (if_pc !== 32'hC) begin n_fail++; $display("FAIL credit_pop3: got %h expected c", if_pc); end
        n_checks++;
        tick();
        if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== (32'h10 ^ MASK)) begin
            n_fail++; $display("FAIL credit_new: got v=%b pc=%h instr=%h expected v=1 pc=10 instr=%h",
                               if_valid, if_pc, if_instr, 32'h10 ^ MASK);
        end
        n_checks++;
    endtask

    task automatic test_flush();
        do_reset();
        gnt = 1'b1; resp_en = 1'b0; ready = 1'b1;
        repeat (4) tick();
        gnt = 1'b0; resp_en = 1'b1;
        tick();
        tick();
        resp_en = 1'b0;
        tick();
        // 0x8 and 0xC are still in flight
        flush_i = 1'b1; flush_addr_i = 32'h100; gnt = 1'b1; resp_en = 1'b1;
        #1;
        if (req !== 1'b0) begin n_fail++; $display("FAIL flush_no_req: got %b expected 0", req); end
        n_checks++;
        tick();
        flush_i = 1'b0;
        #1;
        if (if_valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
            n_fail++; $display("FAIL flush_redirect: got v=%b req=%b addr=%h expected v=0 req=1 addr=100", if_valid, req, addr);
        end
        n_checks++;
        tick();
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop1: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        n_checks++;
        tick();
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop2: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        n_checks++;
        tick();
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== (32'h100 ^ MASK)) begin
            n_fail++; $display("FAIL flush_first: got v=%b pc=%h instr=%h expected v=1 pc=100 instr=%h",
                               if_valid, if_pc, if_instr, 32'h100 ^ MASK);
        end
        n_checks++;
    endtask

    task automatic test_flush_rvalid();
        do_reset();
        gnt = 1'b1; resp_en = 1'b0; ready = 1'b1;
        repeat (2) tick();
        gnt = 1'b0; resp_en = 1'b1;
        tick();
        // response for 0x0 is on the bus this cycle, 0x4 still pending
        flush_i = 1'b1; flush_addr_i = 32'h200; gnt = 1'b1; ready = 1'b0;
        tick();
        flush_i = 1'b0;
        #1;
        if (if_valid !== 1'b0 || req !== 1'b1 || addr !== 32'h200) begin
            n_fail++; $display("FAIL flushrv_redirect: got v=%b req=%b addr=%h expected v=0 req=1 addr=200", if_valid, req, addr);
        end
        n_checks++;
        tick();
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flushrv_drop: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        n_checks++;
        tick();
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== (32'h200 ^ MASK)) begin
            n_fail++; $display("FAIL flushrv_first: got v=%b pc=%h instr=%h expected v=1 pc=200 instr=%h",
                               if_valid, if_pc, if_instr, 32'h200 ^ MASK);
        end
        n_checks++;
        tick();
        if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
            n_fail++; $display("FAIL flushrv_hold: got v=%b pc=%h expected v=1 pc=200", if_valid, if_pc);
        end
        n_checks++;
        ready = 1'b1;
        tick();
        if (if_valid !== 1'b1 || if_pc !== 32'h204) begin
            n_fail++; $display("FAIL flushrv_next: got v=%b pc=%h expected v=1 pc=204", if_valid, if_pc);
        end
        n_checks++;
    endtask

    task automatic test_gnt_withheld();
        do_reset();
        gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (req !== 1'b1 || addr !== 32'h0) begin
                n_fail++; $display("FAIL nognt_hold[%0d]: got req=%b addr=%h expected req=1 addr=0", i, req, addr);
            end
            n_checks++;
            tick();
        end
        flush_i = 1'b1; flush_addr_i = 32'h203;
        tick();
        flush_i = 1'b0;
        #1;
        if (addr !== 32'h200) begin n_fail++; $display("FAIL nognt_align: got %h expected 200", addr); end
        n_checks++;
        gnt = 1'b1;
        tick();
        if (addr !== 32'h204) begin n_fail++; $display("FAIL nognt_advance: got %h expected 204", addr); end
        n_checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL wrap_a0: got req=%b addr=%h expected req=1 addr=fffffff8", w_req, w_addr);
        end
        n_checks++;
        tick();
        if (w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_a1: got %h expected fffffffc", w_addr); end
        n_checks++;
        tick();
        if (w_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_a2: got %h expected 0", w_addr); end
        n_checks++;
        tick();
        if (w_addr !== 32'h4) begin n_fail++; $display("FAIL wrap_a3: got %h expected 4", w_addr); end
        n_checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        gnt = 1'b1; resp_en = 1'b1; ready = 1'b1;
        repeat (4) tick();
        if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
            n_fail++; $display("FAIL areset_pre: got v=%b pc=%h expected v=1 pc=8", if_valid, if_pc);
        end
        n_checks++;
        #2;
        rst = 1'b0;
        #1;
        if (if_valid !== 1'b0 || req !== 1'b0 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL areset_now: got v=%b req=%b pc=%h expected v=0 req=0 pc=0", if_valid, req, if_pc);
        end
        n_checks++;
        do_reset();
        if (req !== 1'b1 || addr !== 32'h0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_release: got req=%b addr=%h v=%b expected req=1 addr=0 v=0", req, addr, if_valid);
        end
        n_checks++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_credit();
        test_flush();
        test_flush_rvalid();
        test_gnt_withheld();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
